// File: rtl/candy_i2c_pkg.sv
// Shared types and sizing for the candy I2C target register bank.
package candy_i2c_pkg;

  localparam int I2C_REG_COUNT = 16;
  localparam int I2C_PTR_W     = 4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    WR_PTR   = 4'd3,
    WR_ACK   = 4'd4,
    WR_DATA  = 4'd5,
    RD_DATA  = 4'd6,
    RD_ACK   = 4'd7,
    IGNORE   = 4'd8
  } i2c_state_e;

endpackage

// File: rtl/candy_i2c_line_sync.sv
// Pin synchronizer with rise/fall detect; CANDY_I2C_TARGET_FILTER_EN adds a
// 3-sample stability filter that rejects glitches of 2 clk or fewer.
module candy_i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
`ifdef CANDY_I2C_TARGET_FILTER_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;
`endif

  // next-state for synchronizer, optional filter history and settled level
  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
`ifdef CANDY_I2C_TARGET_FILTER_EN
    hist1_d = sync2_q;
    hist2_d = hist1_q;
    if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
      level_d = sync2_q;
    end else begin
      level_d = level_q;
    end
`else
    level_d = sync2_q;
`endif
  end

  // state registers; idle bus level is high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
`ifdef CANDY_I2C_TARGET_FILTER_EN
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
`ifdef CANDY_I2C_TARGET_FILTER_EN
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
`endif
    end
  end

  assign level = level_d;
  assign rise  = level_d & ~level_q;
  assign fall  = ~level_d & level_q;

endmodule

// File: rtl/candy_avb_i2c_target.sv
// I2C target with a 16 x 8-bit register bank shared over Avalon-MM.
// Optional input glitch filter: define CANDY_I2C_TARGET_FILTER_EN.
module candy_avb_i2c_target
  import candy_i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        i2c_wr_pulse
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  candy_i2c_line_sync u_scl_sync (
    .clk(clk), .reset_n(reset_n), .pin_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  candy_i2c_line_sync u_sda_sync (
    .clk(clk), .reset_n(reset_n), .pin_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e           state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [I2C_PTR_W-1:0] ptr_q, ptr_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 ack_q, ack_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic [31:0]          readdata_q, readdata_d;
  logic [7:0]           bank_q [I2C_REG_COUNT];
  logic [7:0]           bank_d [I2C_REG_COUNT];

  logic start_s, stop_s, rx_state_s, byte_done_s, i2c_wr_s, host_wr_s;
  logic unused_wdata_s;

  assign start_s       = sda_fall & scl_lvl;
  assign stop_s        = sda_rise & scl_lvl;
  assign rx_state_s    = (state_q == ADDR) || (state_q == WR_PTR) || (state_q == WR_DATA);
  assign byte_done_s   = scl_fall && (bit_cnt_q == 4'd8);
  assign host_wr_s     = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata[31:8];

  // bus FSM: sample SDA on SCL rise, change sda_oe only on SCL fall
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    ack_d     = ack_q;
    i2c_wr_s  = 1'b0;
    if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_s) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      if (rx_state_s && scl_rise && (bit_cnt_q < 4'd8)) begin
        shift_d   = {shift_q[6:0], sda_lvl};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
      case (state_q)
        IDLE, IGNORE: sda_oe_d = 1'b0;
        ADDR: begin
          if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = IGNORE;
            end
          end else begin
            state_d = ADDR;
          end
        end
        WR_PTR, WR_DATA: begin
          if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            state_d   = WR_ACK;
            sda_oe_d  = 1'b1;
            if (state_q == WR_PTR) begin
              ptr_d = shift_q[I2C_PTR_W-1:0];
            end else begin
              ptr_d    = ptr_q + 4'd1;
              i2c_wr_s = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ADDR_ACK, WR_ACK, RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_lvl;
          end else if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if ((state_q == ADDR_ACK && !shift_q[0]) || state_q == WR_ACK) begin
              state_d = (state_q == ADDR_ACK) ? WR_PTR : WR_DATA;
            end else if (state_q == RD_ACK && ack_q) begin
              state_d = IGNORE;
            end else begin
              // read byte starts: drive MSB of reg[ptr] right away
              state_d   = RD_DATA;
              shift_d   = bank_q[ptr_q];
              sda_oe_d  = ~bank_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end
          end else begin
            state_d = state_q;
          end
        end
        RD_DATA: begin
          if (scl_fall && (bit_cnt_q == 4'd8)) begin
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_q + 4'd1;
            bit_cnt_d = 4'd0;
            state_d   = RD_ACK;
          end else if (scl_fall) begin
            sda_oe_d  = ~shift_q[6];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d = RD_DATA;
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // register bank update; host write overrides a same-clock I2C write
  always_comb begin
    bank_d = bank_q;
    if (i2c_wr_s) begin
      bank_d[ptr_q] = shift_q;
    end else begin
      bank_d[ptr_q] = bank_q[ptr_q];
    end
    if (host_wr_s) begin
      bank_d[address] = writedata[7:0];
    end else begin
      bank_d[address] = bank_d[address];
    end
    wr_pulse_d = i2c_wr_s;
    readdata_d = {24'd0, bank_q[address]};
  end

  // state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      ack_q      <= 1'b1;
      wr_pulse_q <= 1'b0;
      readdata_q <= 32'd0;
      for (int i = 0; i < I2C_REG_COUNT; i++) begin
        bank_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      ack_q      <= ack_d;
      wr_pulse_q <= wr_pulse_d;
      readdata_q <= readdata_d;
      bank_q     <= bank_d;
    end
  end

  assign sda_oe       = sda_oe_q;
  assign readdata     = readdata_q;
  assign i2c_wr_pulse = wr_pulse_q;

endmodule
